bcd_to_binary_seq: RTL

//   Sequential BCD-to-binary converter (reverse double-dabble): the inverse path of the

---
 rtl/digital_timer_pkg.sv | 22 ++
 rtl/bcd_digit_adjust.sv | 19 +
 rtl/bcd_to_binary_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/digital_timer_pkg.sv
// ============================================================================
// Module  : digital_timer_pkg
// Purpose : Shared constants and FSM state type for the timer's BCD datapath.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package digital_timer_pkg;

  localparam int          BCD_DIGIT_W   = 4;
  localparam logic [3:0]  DABBLE_THRESH = 4'd8;
  localparam logic [3:0]  DABBLE_ADJ    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module  : bcd_digit_adjust
// Purpose : Reverse double-dabble correction for one BCD digit (>=8 -> -3).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust
  import digital_timer_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= DABBLE_THRESH) ? (digit_in - DABBLE_ADJ) : digit_in;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
// Module  : bcd_to_binary_seq
// Purpose : Sequential BCD-to-binary converter, one shift per clock, with a
//           start/busy/done handshake. Optional macro BCD_CHECK_EN rejects
//           operands holding a digit above 9 and flags them on err.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_binary_seq
  import digital_timer_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                           clk_50MHz,
  input  logic                           reset,
  input  logic                           start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]  bcd_in,
  output logic                           busy,
  output logic                           done,
  output logic [BIN_W-1:0]               bin_out,
  output logic                           err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int R_W   = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIN_W - 1);

  state_t           r_state;
  state_t           w_next;
  logic [R_W-1:0]   r_shreg;
  logic [R_W-1:0]   w_shifted;
  logic [R_W-1:0]   w_corrected;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_bin;
  logic             r_done;
  logic             r_err;
  logic             w_accept;
  logic             w_last;
  logic             w_invalid;

  // Binary bits leave the BCD field through the low end; only BCD digits get corrected.
  assign w_shifted = r_shreg >> 1;
  assign w_corrected[BIN_W-1:0] = w_shifted[BIN_W-1:0];

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_in  (w_shifted  [BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
        .digit_out (w_corrected[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
    end
  endgenerate

`ifdef BCD_CHECK_EN
  logic [DIGITS-1:0] w_digit_bad;
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_check
      assign w_digit_bad[i] = (bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd9);
    end
  endgenerate
  assign w_invalid = |w_digit_bad;
`else
  assign w_invalid = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == SHIFT) && (r_cnt == C_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = w_invalid ? DONE : SHIFT;
      SHIFT:   if (r_cnt == C_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shreg <= {bcd_in, {BIN_W{1'b0}}};
        r_cnt   <= '0;
        if (w_invalid) begin
          r_bin  <= '0;
          r_err  <= 1'b1;
          r_done <= 1'b1;
        end
      end else if (r_state == SHIFT) begin
        r_shreg <= w_corrected;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_bin  <= w_corrected[BIN_W-1:0];
          r_err  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign bin_out = r_bin;
  assign err     = r_err;

endmodule

`default_nettype wire
